// File: rtl/adc_frame_streamer.sv
// Snapshots N_CH ADC/metrology words per sample strobe into a frame FIFO and
// streams each frame, prefixed by its sequence number, over a valid/ready port.
module adc_frame_streamer #(
    parameter int N_CH   = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     sample_valid_i,
    input  logic [N_CH*DATA_W-1:0]   sample_data_i,
    output logic [DATA_W-1:0]        m_tdata_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic                     m_tlast_o,
    output logic [DATA_W-1:0]        seq_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic [LVL_W-1:0]         level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    // state  | meaning
    // S_IDLE | no frame held, tvalid low
    // S_HDR  | presenting sequence-number header of frame at rd_ptr
    // S_DATA | presenting channel ch_idx of frame at rd_ptr
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    logic [DATA_W-1:0] data_mem [DEPTH][N_CH];
    logic [DATA_W-1:0] seq_mem  [DEPTH];

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt;
    logic [CH_W-1:0]   ch_idx, ch_nxt;
    logic              strobe, full, push, pop, hs;

    assign strobe = sample_valid_i & enable_i;
    assign full   = (level_o == LVL_W'(DEPTH));
    assign push   = strobe & ~full;
    assign hs     = m_tvalid_o & m_tready_i;
    assign pop    = hs & m_tlast_o;
    assign rd_nxt = rd_ptr + PTR_W'(1);
    assign ch_nxt = ch_idx + CH_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            seq_mem[wr_ptr] <= seq_o;
            for (int k = 0; k < N_CH; k++) begin
                data_mem[wr_ptr][k] <= sample_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq_o      <= '0;
            drop_cnt_o <= '0;
            level_o    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                seq_o  <= seq_o + DATA_W'(1);
            end
            if (strobe && full && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({push, pop})
                2'b10:   level_o <= level_o + LVL_W'(1);
                2'b01:   level_o <= level_o - LVL_W'(1);
                default: level_o <= level_o;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ch_idx     <= '0;
            m_tdata_o  <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (level_o != '0) begin
                        state      <= S_HDR;
                        m_tvalid_o <= 1'b1;
                        m_tlast_o  <= 1'b0;
                        m_tdata_o  <= seq_mem[rd_ptr];
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        state     <= S_DATA;
                        ch_idx    <= '0;
                        m_tdata_o <= data_mem[rd_ptr][0];
                        m_tlast_o <= (N_CH == 1);
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        if (m_tlast_o) begin
                            ch_idx    <= '0;
                            m_tlast_o <= 1'b0;
                            if ((level_o != LVL_W'(1)) || push) begin
                                state <= S_HDR;
                                // A frame captured this very cycle is not in seq_mem yet
                                m_tdata_o <= (level_o == LVL_W'(1)) ? seq_o : seq_mem[rd_nxt];
                            end else begin
                                state      <= S_IDLE;
                                m_tvalid_o <= 1'b0;
                            end
                        end else begin
                            ch_idx    <= ch_nxt;
                            m_tdata_o <= data_mem[rd_ptr][ch_nxt];
                            m_tlast_o <= (ch_nxt == CH_W'(N_CH - 1));
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    m_tvalid_o <= 1'b0;
                    m_tlast_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Directed bench for adc_frame_streamer: a 12-channel instance for framing and
// flow control, and a narrow 8-bit instance for sequence wrap and drop saturation.
module tb_adc_frame_streamer;

    localparam int N_CH   = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic                   sample_valid = 1'b0;
    logic [N_CH*DATA_W-1:0] sample_data = '0;
    logic [DATA_W-1:0]      tdata;
    logic                   tvalid;
    logic                   tready = 1'b0;
    logic                   tlast;
    logic [DATA_W-1:0]      seq;
    logic [DROP_W-1:0]      drop;
    logic [3:0]             level;

    adc_frame_streamer #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(sample_valid),
        .sample_data_i(sample_data), .m_tdata_o(tdata), .m_tvalid_o(tvalid),
        .m_tready_i(tready), .m_tlast_o(tlast), .seq_o(seq), .drop_cnt_o(drop),
        .level_o(level)
    );

    logic        s_enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready = 1'b0;
    logic        s_tlast;
    logic [7:0]  s_seq;
    logic [3:0]  s_drop;
    logic [1:0]  s_level;

    adc_frame_streamer #(.N_CH(2), .DATA_W(8), .DEPTH(2), .DROP_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .enable_i(s_enable), .sample_valid_i(s_valid),
        .sample_data_i(s_data), .m_tdata_o(s_tdata), .m_tvalid_o(s_tvalid),
        .m_tready_i(s_tready), .m_tlast_o(s_tlast), .seq_o(s_seq), .drop_cnt_o(s_drop),
        .level_o(s_level)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] wq[$];
    logic        lq[$];
    int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] base_of(input int f);
        return 32'h100 + 32'(f) * 32'h1000;
    endfunction

    task automatic cap(input int f);
        for (int k = 0; k < N_CH; k++) sample_data[k*DATA_W +: DATA_W] = base_of(f) + 32'(k);
        enable       = 1'b1;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        enable       = 1'b0;
        tready       = 1'b0;
        s_valid      = 1'b0;
        s_enable     = 1'b0;
        s_tready     = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input int nframes, input bit use_pat, input int max_cyc, output int cyc);
        int          got;
        logic        tv;
        logic        tl;
        logic [31:0] td;
        got = 0;
        cyc = 0;
        while (got < nframes && cyc < max_cyc) begin
            tready = use_pat ? (pat[cyc % 7] != 0) : 1'b1;
            tv = tvalid;
            td = tdata;
            tl = tlast;
            step();
            cyc++;
            if (tv && tready) begin
                wq.push_back(td);
                lq.push_back(tl);
                if (tl) got++;
            end else if (tv) begin
                chk("stall_hold", {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, tl, td});
            end
        end
        tready = 1'b0;
        if (got < nframes) chk("drain_timeout", 64'(got), 64'(nframes));
    endtask

    task automatic check_frames(input logic [31:0] hdr0, input int nframes, input int first_f);
        int idx;
        chk("word_count", 64'(wq.size()), 64'(nframes * (N_CH + 1)));
        for (int f = 0; f < nframes; f++) begin
            for (int j = 0; j <= N_CH; j++) begin
                idx = f * (N_CH + 1) + j;
                if (idx < wq.size()) begin
                    chk("word", 64'(wq[idx]), (j == 0) ? 64'(hdr0 + 32'(f)) : 64'(base_of(first_f + f) + 32'(j - 1)));
                    chk("tlast", 64'(lq[idx]), 64'(j == N_CH));
                end
            end
        end
        wq.delete();
        lq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [7:0]  s_exp_d[6] = '{8'hFF, 8'h11, 8'h22, 8'h00, 8'h33, 8'h44};
        logic        s_exp_l[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_seq", 64'(seq), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        rst_n = 1'b1;
        step();

        // single frame, latency and sustained rate
        tready = 1'b1;
        cap(0);
        chk("t1_level1", 64'(level), 64'd1);
        chk("t1_tvalid_early", 64'(tvalid), 64'd0);
        step();
        chk("t1_hdr_valid", 64'(tvalid), 64'd1);
        chk("t1_hdr_data", 64'(tdata), 64'd0);
        drain(1, 1'b0, 100, cyc);
        chk("t1_cycles", 64'(cyc), 64'd13);
        check_frames(32'd0, 1, 0);
        chk("t1_level0", 64'(level), 64'd0);
        chk("t1_idle", 64'(tvalid), 64'd0);
        chk("t1_seq", 64'(seq), 64'd1);

        // capture coincident with tlast pop of the only stored frame
        do_reset();
        tready = 1'b1;
        cap(0);
        repeat (13) step();
        cap(1);
        chk("t1b_level", 64'(level), 64'd1);
        chk("t1b_tvalid", 64'(tvalid), 64'd1);
        chk("t1b_hdr", 64'(tdata), 64'd1);
        drain(1, 1'b0, 50, cyc);
        chk("t1b_cycles", 64'(cyc), 64'd13);
        check_frames(32'd1, 1, 1);

        // backpressure over three frames
        do_reset();
        cap(0);
        cap(1);
        cap(2);
        chk("t2_level3", 64'(level), 64'd3);
        drain(3, 1'b1, 400, cyc);
        check_frames(32'd0, 3, 0);
        chk("t2_level0", 64'(level), 64'd0);

        // overflow then full drain
        do_reset();
        for (int i = 0; i < 11; i++) cap(i);
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_drop", 64'(drop), 64'd3);
        chk("t3_seq", 64'(seq), 64'd8);
        drain(8, 1'b0, 200, cyc);
        chk("t3_cycles", 64'(cyc), 64'd104);
        check_frames(32'd0, 8, 0);
        tready = 1'b1;
        repeat (5) step();
        chk("t3_no_extra", 64'(tvalid), 64'd0);
        chk("t3_level0", 64'(level), 64'd0);
        tready = 1'b0;

        // full FIFO: strobe coincident with tlast handshake is dropped
        do_reset();
        for (int i = 0; i < 8; i++) cap(i);
        tready = 1'b1;
        repeat (12) step();
        chk("t4_at_tlast", 64'(tlast), 64'd1);
        cap(20);
        tready = 1'b0;
        chk("t4_level", 64'(level), 64'd7);
        chk("t4_drop", 64'(drop), 64'd1);
        chk("t4_seq", 64'(seq), 64'd8);
        chk("t4_next_hdr", 64'(tdata), 64'd1);
        cap(21);
        chk("t4_refill", 64'(level), 64'd8);
        chk("t4_seq9", 64'(seq), 64'd9);

        // enable low: strobes ignored, full or empty
        enable       = 1'b0;
        sample_valid = 1'b1;
        repeat (3) step();
        sample_valid = 1'b0;
        chk("t5_full_drop", 64'(drop), 64'd1);
        chk("t5_full_seq", 64'(seq), 64'd9);
        do_reset();
        sample_valid = 1'b1;
        repeat (3) step();
        sample_valid = 1'b0;
        step();
        chk("t5_empty_level", 64'(level), 64'd0);
        chk("t5_empty_seq", 64'(seq), 64'd0);
        chk("t5_empty_tvalid", 64'(tvalid), 64'd0);

        // reset mid-frame
        do_reset();
        cap(0);
        cap(1);
        cap(2);
        tready = 1'b1;
        repeat (5) step();
        tready = 1'b0;
        chk("t6_mid_word", 64'(tdata), 64'(base_of(0) + 32'd4));
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 64'(tvalid), 64'd0);
        chk("t6_tlast", 64'(tlast), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_seq", 64'(seq), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        cap(5);
        drain(1, 1'b0, 50, cyc);
        check_frames(32'd0, 1, 5);

        // narrow instance: sequence wrap
        do_reset();
        s_enable = 1'b1;
        s_tready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            s_data  = 16'(i);
            s_valid = 1'b1;
            step();
            s_valid = 1'b0;
            repeat (3) step();
        end
        repeat (10) step();
        chk("w_seq_ff", 64'(s_seq), 64'hFF);
        chk("w_level0", 64'(s_level), 64'd0);
        chk("w_drop0", 64'(s_drop), 64'd0);
        s_tready = 1'b0;
        s_data   = 16'h2211;
        s_valid  = 1'b1;
        step();
        s_data = 16'h4433;
        step();
        s_valid = 1'b0;
        chk("w_seq_01", 64'(s_seq), 64'h01);
        chk("w_level2", 64'(s_level), 64'd2);
        step();
        chk("w_hdr_valid", 64'(s_tvalid), 64'd1);
        s_tready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("w_word", {55'd0, s_tvalid, s_tdata}, {55'd0, 1'b1, s_exp_d[j]});
            chk("w_tlast", 64'(s_tlast), 64'(s_exp_l[j]));
            step();
        end
        chk("w_level_end", 64'(s_level), 64'd0);

        // narrow instance: drop counter saturation
        s_tready = 1'b0;
        s_valid  = 1'b1;
        repeat (22) step();
        s_valid = 1'b0;
        chk("w_drop_sat", 64'(s_drop), 64'hF);
        chk("w_seq_03", 64'(s_seq), 64'h03);
        chk("w_level_full", 64'(s_level), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
